// File: rtl/sw_max_tracker_pkg.sv
// sw_max_tracker_pkg: shared score width and FSM state encodings for the max tracker
package sw_max_tracker_pkg;
    localparam int V_E_F_BIT = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sw_max_tracker_sm_gt.sv
// sm_gt: strict sign-magnitude greater-than (a > b, +0 and -0 equal); ports a, b in, gt out
module sm_gt #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt
);
    logic a_s, b_s, both_zero;
    logic [DATA_WIDTH-2:0] a_m, b_m;
    assign a_s = a[DATA_WIDTH-1];
    assign b_s = b[DATA_WIDTH-1];
    assign a_m = a[DATA_WIDTH-2:0];
    assign b_m = b[DATA_WIDTH-2:0];
    assign both_zero = (a_m == '0) && (b_m == '0);
    // a zero magnitude on one side still orders correctly by sign, so only the double-zero case is special
    always_comb
        gt = both_zero ? 1'b0 :
             (a_s != b_s) ? !a_s :
             a_s ? (a_m < b_m) : (a_m > b_m);
endmodule

// File: rtl/sw_max_tracker.sv
// sw_max_tracker: running argmax over a raster-ordered sign-magnitude score stream
// ports: clk/rst; i_start with i_rows/i_cols begins a matrix; i_valid/i_score beats accepted
// while o_ready; o_busy in RUN; o_done pulses on entry to DONE; o_max_* report the best score/coords
module sw_max_tracker
    import sw_max_tracker_pkg::*;
#(
    parameter int DATA_WIDTH = V_E_F_BIT,
    parameter int ROW_BITS   = 10,
    parameter int COL_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ROW_BITS-1:0]   i_rows,
    input  logic [COL_BITS-1:0]   i_cols,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_score,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_max_score,
    output logic [ROW_BITS-1:0]   o_max_row,
    output logic [COL_BITS-1:0]   o_max_col
);
    localparam logic [DATA_WIDTH-1:0] SM_MIN = '1;
    state_t state;
    logic [ROW_BITS-1:0] rows, row_cnt;
    logic [COL_BITS-1:0] cols, col_cnt;
    logic gt, last_col, last_row;
    sm_gt #(.DATA_WIDTH(DATA_WIDTH)) u_gt (.a(i_score), .b(o_max_score), .gt(gt));
    assign o_ready  = (state == RUN);
    assign o_busy   = (state == RUN);
    assign last_col = (col_cnt == cols - 1'b1);
    assign last_row = (row_cnt == rows - 1'b1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_done      <= 1'b0;
            o_max_score <= '0;
            o_max_row   <= '0;
            o_max_col   <= '0;
            rows        <= '0;
            cols        <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
        end else begin
            o_done <= 1'b0;
            if (state != RUN) begin
                if (i_start) begin
                    rows        <= i_rows;
                    cols        <= i_cols;
                    row_cnt     <= '0;
                    col_cnt     <= '0;
                    o_max_score <= SM_MIN;
                    o_max_row   <= '0;
                    o_max_col   <= '0;
                    // an empty matrix has nothing to stream, so it completes immediately
                    if (i_rows == '0 || i_cols == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
            end else if (i_valid) begin
                if (gt) begin
                    o_max_score <= i_score;
                    o_max_row   <= row_cnt;
                    o_max_col   <= col_cnt;
                end
                if (last_col && last_row) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end else if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sw_max_tracker.sv
// tb_sw_max_tracker: scoreboard-driven bench for sw_max_tracker
module tb_sw_max_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_rows = '0;
    logic [9:0]  i_cols = '0;
    logic        i_valid = 1'b0;
    logic [15:0] i_score = '0;
    logic        o_ready, o_busy, o_done;
    logic [15:0] o_max_score;
    logic [9:0]  o_max_row, o_max_col;

    typedef struct {
        logic [15:0] score;
        logic [9:0]  row;
        logic [9:0]  col;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] beats[$];
    int          checks = 0;
    int          passed = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sw_max_tracker dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rows(i_rows), .i_cols(i_cols),
        .i_valid(i_valid), .i_score(i_score), .o_ready(o_ready), .o_busy(o_busy),
        .o_done(o_done), .o_max_score(o_max_score), .o_max_row(o_max_row), .o_max_col(o_max_col)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int sm_val(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    task automatic push_expected(input int r, input int c);
        exp_t e;
        int   best;
        e.score = 16'hFFFF;
        e.row = '0;
        e.col = '0;
        best = sm_val(e.score);
        for (int i = 0; i < beats.size(); i++) begin
            if (sm_val(beats[i]) > best) begin
                best = sm_val(beats[i]);
                e.score = beats[i];
                e.row = 10'(i / c);
                e.col = 10'(i % c);
            end
        end
        if (r == 0 || c == 0) e.score = 16'hFFFF;
        sb.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end else passed++;
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (o_max_score !== e.score) begin
            fails++;
            $display("FAIL %s score: got %h want %h", name, o_max_score, e.score);
        end else passed++;
        checks++;
        if (o_max_row !== e.row) begin
            fails++;
            $display("FAIL %s row: got %0d want %0d", name, o_max_row, e.row);
        end else passed++;
        checks++;
        if (o_max_col !== e.col) begin
            fails++;
            $display("FAIL %s col: got %0d want %0d", name, o_max_col, e.col);
        end else passed++;
    endtask

    // runs one matrix from `beats`; mid_start >= 0 pulses i_start (rows=0) alongside that beat
    task automatic run_matrix(input string name, input int r, input int c, input int gap, input int mid_start);
        int bound;
        push_expected(r, c);
        i_start = 1'b1;
        i_rows = 10'(r);
        i_cols = 10'(c);
        cycle();
        i_start = 1'b0;
        if (r == 0 || c == 0) begin
            check_bit({name, " zero done"}, o_done, 1'b1);
            check_bit({name, " zero ready"}, o_ready, 1'b0);
            check_result(name);
            cycle();
            check_bit({name, " zero ready later"}, o_ready, 1'b0);
            return;
        end
        check_bit({name, " ready"}, o_ready, 1'b1);
        check_bit({name, " done low at start"}, o_done, 1'b0);
        for (int i = 0; i < beats.size(); i++) begin
            i_valid = 1'b1;
            i_score = beats[i];
            if (i == mid_start) begin
                i_start = 1'b1;
                i_rows = '0;
                i_cols = '0;
            end
            cycle();
            i_valid = 1'b0;
            i_start = 1'b0;
            if (i < beats.size() - 1) begin
                if (o_done !== 1'b0 || o_busy !== 1'b1) begin
                    checks++;
                    fails++;
                    $display("FAIL %s early end at beat %0d: done %b busy %b want 0 1", name, i, o_done, o_busy);
                end
                for (int g = 0; g < gap; g++) cycle();
            end
        end
        bound = 0;
        while (o_done !== 1'b1 && bound < 4) begin
            bound++;
            cycle();
        end
        check_bit({name, " done latency"}, (bound == 0) ? o_done : 1'b0, 1'b1);
        check_bit({name, " busy off"}, o_busy, 1'b0);
        check_result(name);
        cycle();
        check_bit({name, " done pulse"}, o_done, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_bit("reset ready", o_ready, 1'b0);
        check_bit("reset busy", o_busy, 1'b0);
        check_bit("reset done", o_done, 1'b0);
        checks++;
        if ({o_max_score, o_max_row, o_max_col} !== 36'd0) begin
            fails++;
            $display("FAIL reset results: got %h %0d %0d want 0 0 0", o_max_score, o_max_row, o_max_col);
        end else passed++;
    endtask

    task automatic test_basic();
        beats = '{16'd5, 16'd9, 16'd3, 16'd9, 16'h8004, 16'd0};
        run_matrix("basic", 2, 3, 0, -1);
    endtask

    task automatic test_negative();
        beats = '{16'h8007, 16'h8002, 16'h8002, 16'h8009};
        run_matrix("negative", 1, 4, 0, -1);
    endtask

    task automatic test_zero_len();
        beats = {};
        run_matrix("zero rows", 0, 5, 0, -1);
        run_matrix("zero cols", 3, 0, 0, -1);
    endtask

    task automatic test_signed_zero();
        beats = '{16'h0000, 16'h8000, 16'h8000};
        run_matrix("signed zero", 1, 3, 0, -1);
        run_matrix("signed zero gaps", 1, 3, 2, -1);
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1;
        i_rows = 10'd2;
        i_cols = 10'd3;
        cycle();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_score = 16'd100;
            cycle();
        end
        i_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_bit("mid reset busy", o_busy, 1'b0);
        checks++;
        if ({o_max_score, o_max_row, o_max_col} !== 36'd0) begin
            fails++;
            $display("FAIL mid reset results: got %h %0d %0d want 0 0 0", o_max_score, o_max_row, o_max_col);
        end else passed++;
        beats = '{16'd1, 16'd4};
        run_matrix("after reset", 1, 2, 0, -1);
    endtask

    task automatic test_back_to_back();
        beats = '{16'd2, 16'd8, 16'd5, 16'h8001, 16'd8, 16'd7};
        run_matrix("mid start", 2, 3, 1, 1);
        beats = '{16'd3, 16'd1, 16'd6, 16'd6};
        run_matrix("back to back", 2, 2, 0, -1);
    endtask

    task automatic test_done_hold();
        logic [35:0] held;
        held = {o_max_score, o_max_row, o_max_col};
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_score = 16'h7FFF;
            cycle();
            check_bit("done hold ready", o_ready, 1'b0);
        end
        i_valid = 1'b0;
        checks++;
        if ({o_max_score, o_max_row, o_max_col} !== held || held !== {16'd6, 10'd1, 10'd0}) begin
            fails++;
            $display("FAIL done hold: got %h %0d %0d want 0006 1 0", o_max_score, o_max_row, o_max_col);
        end else passed++;
        check_bit("done hold no pulse", o_done, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_zero_len();
        test_signed_zero();
        test_reset_mid();
        test_back_to_back();
        test_done_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
